ram_master: RTL

//  Initiator side of the single-port ram interface (cen/wen/addr/data_in/data_out).

---
 rtl/ram_master_pkg.sv | 27 ++
 rtl/ram_master_req_fifo.sv | 61 ++++++
 rtl/ram_master.sv | 96 +++++++++
 3 files changed

// File: rtl/ram_master_pkg.sv
// Shared types and constants for the ram_master initiator: the request record,
// the issue FSM states and the rule that decides when the queue head may issue.
package ram_master_pkg;

    localparam int DATA_W          = 16;
    localparam int RMST_FIFO_DEPTH = 4;

    typedef enum logic {
        RMST_IDLE   = 1'b0,
        RMST_ACCESS = 1'b1
    } rmst_state_t;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    localparam int REQ_W = $bits(req_t);

    // Writes stream freely; a read needs the response slot empty and no other read on the bus.
    function automatic logic can_issue(input req_t head, input logic empty,
                                       input logic rsp_pending, input logic read_on_bus);
        return !empty && (head.we || (!rsp_pending && !read_on_bus));
    endfunction

endpackage

// File: rtl/ram_master_req_fifo.sv
// Synchronous request queue: power-of-two depth, wrapping pointers, occupancy count.
// Storage is read asynchronously at the read pointer so the head is visible before the pop edge.
module req_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = storage[rd_ptr];

    // NOTE: payload storage has no reset; the count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            storage[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_master.sv
// Initiator for the single-port ram: queues requests in order, drives one registered
// ram access per cycle and holds returned read data until the consumer takes it.
module ram_master
    import ram_master_pkg::*;
#(
    parameter int FIFO_DEPTH = RMST_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              mem_cen,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    rmst_state_t                  state;
    req_t                         req_in;
    req_t                         head;
    logic [REQ_W-1:0]             fifo_dout;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;
    logic                         push;
    logic                         issue;
    logic                         read_on_bus;

    assign req_in    = '{we: req_we, addr: req_addr, wdata: req_wdata};
    assign req_ready = !fifo_full;
    assign push      = req_valid && req_ready;
    assign head      = req_t'(fifo_dout);

    assign read_on_bus = (state == RMST_ACCESS) && !mem_wen;
    assign issue       = can_issue(head, fifo_empty, rsp_valid, read_on_bus);

    assign busy = (fifo_count != '0) || (state == RMST_ACCESS) || rsp_valid;

    req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (issue),
        .din   (req_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Issue FSM: every access lasts exactly one cycle; addr/wdata hold between accesses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RMST_IDLE;
            mem_cen   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (issue) begin
            state     <= RMST_ACCESS;
            mem_cen   <= 1'b1;
            mem_wen   <= head.we;
            mem_addr  <= head.addr;
            mem_wdata <= head.wdata;
        end else begin
            state   <= RMST_IDLE;
            mem_cen <= 1'b0;
            mem_wen <= 1'b0;
        end
    end

    // mem_rdata is only driven while a read is on the bus, so it is sampled nowhere else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else if (read_on_bus) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= mem_rdata;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
